// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the push-button debouncer.
// The optional DEBOUNCE_PULSE_AUTOREPEAT_EN build widens the counter to cover the repeat period.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        PRESSED   = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    // The repeat period only sizes the counter when autorepeat is built in.
    function automatic int cnt_width(input int stable_cycles,
                                     input int repeat_cycles,
                                     input bit repeat_on);
        int span;
        span = stable_cycles;
        if (repeat_on && (repeat_cycles > span)) begin
            span = repeat_cycles;
        end
        return $clog2(span + 1);
    endfunction

endpackage

// File: rtl/debounce_pulse_if.sv
// Button-side bundle of the debouncer: raw pin in, one-cycle enable pulse and debounced level out.
interface debounce_pulse_if;

    logic btn_in;
    logic x;
    logic level;

    modport master (
        output btn_in,
        input  x,
        input  level
    );

    modport slave (
        input  btn_in,
        output x,
        output level
    );

endinterface

// File: rtl/btn_sync.sv
// Multi-flop synchronizer for an asynchronous pin; output follows the input SYNC_STAGES edges later.
module btn_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_pulse.sv
// Debounces a raw push-button into a registered level and a one-cycle count-enable pulse x.
// Define DEBOUNCE_PULSE_AUTOREPEAT_EN to re-issue x every REPEAT_CYCLES while the button is held.
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    debounce_pulse_if.slave  bus
);

`ifdef DEBOUNCE_PULSE_AUTOREPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    localparam int CNT_W = cnt_width(STABLE_CYCLES, REPEAT_CYCLES, REPEAT_ON);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef DEBOUNCE_PULSE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic             s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             x_q;
    logic             level_q;

    btn_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.btn_in),
        .q     (s)
    );

    // x defaults low every cycle so a pulse can never last more than one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            x_q     <= 1'b0;
            level_q <= 1'b0;
        end else begin
            x_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= WAIT_HIGH;
                        cnt   <= CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state   <= PRESSED;
                        cnt     <= '0;
                        level_q <= 1'b1;
                        x_q     <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state <= WAIT_LOW;
                        cnt   <= CNT_ONE;
                    end
`ifdef DEBOUNCE_PULSE_AUTOREPEAT_EN
                    // Reaching REPEAT_LAST marks REPEAT_CYCLES edges since the previous pulse.
                    else if (cnt == REPEAT_LAST) begin
                        x_q <= 1'b1;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
`endif
                end
                WAIT_LOW: begin
                    if (s) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.x     = x_q;
    assign bus.level = level_q;

endmodule
